// File: rtl/imem_loader.sv
// imem_loader: assembles a framed little-endian byte stream into 32-bit words and writes them to instruction memory.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK} state_t;
    state_t state;
    logic [15:0] len;
    logic [15:0] len_new;
    logic [ADDR_W-1:0] addr;
    logic [1:0] idx;
    logic [23:0] word;
    logic [7:0] sum;
    logic acc;
    assign byte_ready = state == LEN_LO || state == LEN_HI || state == DATA || state == CHK;
    assign mem_we = state == WRITE;
    assign cpu_hold = busy;
    assign acc = byte_valid && byte_ready;
    assign len_new = {byte_data, len[7:0]};
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len <= '0;
            addr <= '0;
            idx <= '0;
            word <= '0;
            sum <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 2'b00;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LEN_LO;
                    busy <= 1'b1;
                    done <= 1'b0;
                    err <= 2'b00;
                end
                LEN_LO: if (acc) begin
                    len[7:0] <= byte_data;
                    state <= LEN_HI;
                end
                LEN_HI: if (acc) begin
                    len <= len_new;
                    if (len_new == 16'd0 || 32'(len_new) > DEPTH) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        err <= 2'b01;
                    end else begin
                        state <= DATA;
                        addr <= '0;
                        idx <= '0;
                        sum <= '0;
                    end
                end
                // bytes shift in from the top so byte 0 lands in bits 7:0 once the word is complete
                DATA: if (acc) begin
                    sum <= sum + byte_data;
                    idx <= idx + 2'd1;
                    word <= {byte_data, word[23:8]};
                    if (idx == 2'd3) begin
                        mem_wdata <= {byte_data, word};
                        mem_addr <= addr;
                        state <= WRITE;
                    end
                end
                WRITE: if (16'(addr) == len - 16'd1) state <= CHK;
                else begin
                    addr <= addr + 1'b1;
                    state <= DATA;
                end
                CHK: if (acc) begin
                    err <= byte_data == sum ? 2'b00 : 2'b10;
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized framed loads checked by a write/result scoreboard fed from a frame-level model.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset, start, byte_valid;
    logic [7:0] byte_data;
    logic byte_ready, mem_we, busy, cpu_hold, done;
    logic [9:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0] err;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] img[$];
    int exp_addr[$];
    logic [31:0] exp_data[$];
    logic [1:0] exp_err[$];
    logic done_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write and every session end is matched against the model queues
    always @(negedge clk) begin
        int a;
        logic [31:0] d;
        logic [1:0] e;
        if (mem_we) begin
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", mem_addr, mem_wdata);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                chk("wr_addr", 32'(mem_addr), a);
                chk("wr_data", mem_wdata, d);
            end
        end
        if (done && !done_d) begin
            if (exp_err.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done with err %0d, required no completion", err);
            end else begin
                e = exp_err.pop_front();
                chk("err", 32'(err), 32'(e));
                chk("busy_at_done", 32'(busy), 0);
                chk("hold_at_done", 32'(cpu_hold), 0);
            end
        end
        done_d = done;
    end

    task automatic send(input logic [7:0] b, input int gapmax, input bit st);
        int n = 0;
        @(negedge clk);
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        start = st;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!byte_ready) chk("byte_accept_timeout", 0, 1);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic begin_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("hold_after_start", 32'(cpu_hold), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        @(negedge clk);
        chk("ready_after_done", 32'(byte_ready), 0);
        chk("writes_outstanding", exp_addr.size(), 0);
    endtask

    // model: words are the image read four bytes at a time little-endian; checksum is the byte sum mod 256
    task automatic run_frame(input int len, input bit bad_chk, input int gapmax, input bit mid_start);
        logic [7:0] s = 8'h00;
        bit bad_len = len == 0 || len > 1024;
        begin_session();
        if (!bad_len)
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back({img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
            end
        foreach (img[i]) s += img[i];
        exp_err.push_back(bad_len ? 2'b01 : bad_chk ? 2'b10 : 2'b00);
        send(8'(len), gapmax, 1'b0);
        send(8'(len >> 8), gapmax, 1'b0);
        if (!bad_len) begin
            foreach (img[i]) send(img[i], gapmax, mid_start && i == 5);
            send(bad_chk ? s ^ 8'h5A : s, gapmax, 1'b0);
        end
        wait_done();
    endtask

    task automatic rand_img(input int len);
        img.delete();
        for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b0;

        img = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_frame(1, 1'b0, 0, 1'b0);
        img.delete();
        run_frame(0, 1'b0, 1, 1'b0);
        run_frame(1025, 1'b0, 1, 1'b0);
        rand_img(2);
        run_frame(2, 1'b1, 2, 1'b0);
        rand_img(7);
        run_frame(7, 1'b0, 1, 1'b1);

        begin_session();
        send(8'h01, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'hAA, 0, 1'b0);
        send(8'hBB, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_we", 32'(mem_we), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_hold", 32'(cpu_hold), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_ready", 32'(byte_ready), 0);
        rand_img(3);
        run_frame(3, 1'b0, 1, 1'b0);

        rand_img(1024);
        run_frame(1024, 1'b0, 3, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_writes_left", exp_addr.size(), 0);
        chk("final_results_left", exp_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
